uart_tx_rr_scheduler: RTL and testbench

//  Shares one uart_tx instance among NUM_REQ byte requesters with round-robin arbitration.
//  - Captures one byte per valid/ready handshake.
//  - Sequences the start/busy protocol of uart_tx.
//  - Enforces an inter-frame gap between frames.
//  - Flags a transmitter that never goes busy.

---
 rtl/uart_tx_rr_scheduler_pkg.sv | 20 ++
 rtl/uart_tx_rr_scheduler_if.sv | 23 ++
 rtl/uart_tx_rr_scheduler_pick.sv | 25 ++
 rtl/uart_tx_rr_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_rr_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin UART TX scheduler.
package uart_tx_rr_scheduler_pkg;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // Bits needed to hold a count of 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_rr_scheduler_if.sv
// Requester byte handshake plus the uart_tx start/busy link.
interface uart_tx_rr_scheduler_if
  import uart_tx_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_rr_scheduler_pick.sv
// Round-robin pick: first valid requester after last_i, wrapping.
module uart_tx_rr_scheduler_pick
  import uart_tx_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     last_i,
  output logic               any_o,
  output logic [IDW-1:0]     idx_o
);

  // Scan from farthest to nearest so the nearest valid wins.
  always_comb begin
    logic [IDW-1:0] j;
    any_o = |valid_i;
    idx_o = last_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDW'((int'(last_i) + k) % NUM_REQ);
      if (valid_i[j]) idx_o = j;
    end
  end

endmodule

// File: rtl/uart_tx_rr_scheduler.sv
// Shares one uart_tx among NUM_REQ byte sources, round-robin.
module uart_tx_rr_scheduler
  import uart_tx_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8192,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_rr_scheduler_if.slave bus,
  output logic [IDW-1:0]        grant_id_o,
  output logic                  active_o,
  output logic                  timeout_err_o,
  output logic [15:0]           frames_sent_o
);

  localparam int TW = cnt_w(BUSY_TIMEOUT);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST =
    TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] REQ_ONE =
    NUM_REQ'(1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [TW-1:0]      tout_q, tout_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [15:0]        frames_q, frames_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic               active_q, active_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;

  logic               pick_any;
  logic [IDW-1:0]     pick_idx;
  logic [7:0]         pick_byte;

  uart_tx_rr_scheduler_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .valid_i (bus.req_valid),
    .last_i  (last_q),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == pick_idx) pick_byte = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    tout_d   = tout_q;
    gap_d    = gap_q;
    frames_d = frames_q;
    err_d    = err_q;
    start_d  = start_q;
    data_d   = data_q;
    ready_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          data_d  = pick_byte;
          gid_d   = pick_idx;
          last_d  = pick_idx;
          ready_d = REQ_ONE << pick_idx;
          start_d = 1'b1;
          tout_d  = '0;
          state_d = S_START;
        end
      end
      // Busy is checked first so it wins over a same-cycle timeout.
      S_START: begin
        if (bus.tx_busy) begin
          start_d = 1'b0;
          state_d = S_WAIT;
        end else if (tout_q == TOUT_LAST) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          frames_d = frames_q + 16'd1;
          gap_d    = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (GAP_CYCLES == 0 || gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign active_d = (state_d != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(NUM_REQ - 1);
      gid_q    <= '0;
      tout_q   <= '0;
      gap_q    <= '0;
      frames_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      data_q   <= '0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      tout_q   <= tout_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
      err_q    <= err_d;
      start_q  <= start_d;
      active_q <= active_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.tx_start   = start_q;
  assign bus.tx_data    = data_q;
  assign grant_id_o     = gid_q;
  assign active_o       = active_q;
  assign timeout_err_o  = err_q;
  assign frames_sent_o  = frames_q;

endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// Scoreboard bench for uart_tx_rr_scheduler with a uart_tx stub.
module tb_uart_tx_rr_scheduler;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int BT  = 64;
  localparam int IDW = 2;

  typedef struct {
    bit counted;
    int slen;
  } frm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_rr_scheduler_if #(.NUM_REQ(N)) ifc ();

  logic [IDW-1:0] grant_id;
  logic           active;
  logic           terr;
  logic [15:0]    frames;

  uart_tx_rr_scheduler #(
    .NUM_REQ      (N),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (ifc),
    .grant_id_o    (grant_id),
    .active_o      (active),
    .timeout_err_o (terr),
    .frames_sent_o (frames)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] pend_q [N][$];
  logic [7:0] exp_q  [N][$];
  frm_t       frm_q[$];
  int         grant_log[$];

  int stub_d     = 2;
  int stub_len   = 4340;
  bit stub_never = 1'b0;

  int exp_frames = 0;
  bit exp_err    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Next owner: first valid requester after the previous owner.
  function automatic int rr(input logic [N-1:0] v, input int last);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit pend_empty();
    for (int i = 0; i < N; i++) if (pend_q[i].size() != 0) return 0;
    return 1;
  endfunction

  // uart_tx stub: busy rises stub_d clk after start, lasts stub_len clk.
  int st_s, st_cnt, st_dl, st_ll;
  bit st_nl;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc.tx_busy <= 1'b0;
      st_s        <= 0;
      st_cnt      <= 0;
      st_dl       <= 2;
      st_ll       <= 1;
      st_nl       <= 1'b0;
    end else begin
      case (st_s)
        0: if (ifc.tx_start) begin
          st_s   <= 1;
          st_cnt <= 1;
          st_dl  <= stub_d;
          st_ll  <= stub_len;
          st_nl  <= stub_never;
        end
        1: if (!ifc.tx_start) begin
          st_s <= 0;
        end else if (!st_nl) begin
          if (st_cnt + 1 >= st_dl) begin
            ifc.tx_busy <= 1'b1;
            st_s        <= 2;
            st_cnt      <= 0;
          end else begin
            st_cnt <= st_cnt + 1;
          end
        end
        2: if (st_cnt + 1 >= st_ll) begin
          ifc.tx_busy <= 1'b0;
          st_s        <= 3;
        end else begin
          st_cnt <= st_cnt + 1;
        end
        default: if (!ifc.tx_start) st_s <= 0;
      endcase
    end
  end

  // Requester driver: holds valid until ready, then takes next byte.
  initial begin : drv
    logic [7:0] b;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        ifc.req_valid = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ifc.req_valid[i] && ifc.req_ready[i])
            ifc.req_valid[i] = 1'b0;
          if (!ifc.req_valid[i] && pend_q[i].size() > 0) begin
            b = pend_q[i].pop_front();
            ifc.req_data[8*i +: 8] = b;
            ifc.req_valid[i] = 1'b1;
            exp_q[i].push_back(b);
          end
        end
      end
    end
  end

  // Monitor: pops expected bytes/outcomes as the DUT presents them.
  initial begin : mon
    logic [N-1:0] pv;
    bit   pa, ps, lastc;
    int   mlast, scnt, gcnt, idx, e;
    frm_t f;
    pv = '0; pa = 0; ps = 0; lastc = 0;
    mlast = N - 1; scnt = 0; gcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) exp_q[i].delete();
        frm_q.delete();
        grant_log.delete();
        exp_frames = 0;
        exp_err    = 1'b0;
        mlast = N - 1;
        pv = '0; pa = 0; ps = 0; lastc = 0;
        scnt = 0; gcnt = 0;
        continue;
      end
      if (ifc.req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(ifc.req_ready)), 1);
        idx = 0;
        for (int i = N - 1; i >= 0; i--)
          if (ifc.req_ready[i]) idx = i;
        e = rr(pv, mlast);
        chk("grant_rr", idx, e);
        chk("grant_id", grant_id, idx);
        chk("grant_edge", {pa, ifc.tx_start, active}, 3'b011);
        chk("byte_pending", 32'(exp_q[idx].size() > 0), 1);
        if (exp_q[idx].size() > 0)
          chk("tx_data", ifc.tx_data, exp_q[idx].pop_front());
        f.counted = !stub_never && (stub_d + 1 <= BT);
        f.slen    = f.counted ? stub_d + 1 : BT;
        frm_q.push_back(f);
        grant_log.push_back(idx);
        mlast = idx;
        scnt  = 0;
      end
      if (ifc.tx_start) scnt++;
      if (ps && !ifc.tx_start) begin
        chk("frame_queued", frm_q.size(), 1);
        if (frm_q.size() > 0) begin
          f = frm_q.pop_front();
          chk("start_len", scnt, f.slen);
          lastc = f.counted;
          if (f.counted) exp_frames = (exp_frames + 1) & 16'hFFFF;
          else exp_err = 1'b1;
        end
      end
      if (ifc.tx_busy || ifc.tx_start) gcnt = 0;
      else if (active) gcnt++;
      if (pa && !active) begin
        if (lastc) chk("gap_len", gcnt, GAP + 1);
        chk("frames_sent", frames, exp_frames);
        chk("timeout_err", terr, exp_err);
      end
      pv = ifc.req_valid;
      pa = active;
      ps = ifc.tx_start;
    end
  end

  task automatic quiet(input string nm, input int maxc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(pend_empty() && ifc.req_valid == '0 && !active)
               && c < maxc);
    chk({nm, "_done"}, 32'(c < maxc), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend_q[i].delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, ifc.req_ready, 0);
    chk({nm, "_start"}, ifc.tx_start, 0);
    chk({nm, "_data"}, ifc.tx_data, 0);
    chk({nm, "_gid"}, grant_id, 0);
    chk({nm, "_active"}, active, 0);
    chk({nm, "_err"}, terr, 0);
    chk({nm, "_frames"}, frames, 0);
  endtask

  initial begin : seq
    int c;
    int mask;
    int r;
    repeat (3) @(posedge clk);
    #3;
    chk_zero("rst0");
    @(negedge clk);
    rst = 1'b0;

    // 1: single request, full-length busy
    pend_q[0].push_back(8'h11);
    quiet("t1", 6000);
    chk("t1_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t1_gid", grant_log[0], 0);
    chk("t1_frames", frames, 1);
    chk("t1_txdata", ifc.tx_data, 8'h11);

    // 2: all requesters held valid for 8 frames
    do_reset();
    stub_len = 40;
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++)
        pend_q[i].push_back(8'(8'hA0 + i));
    quiet("t2", 3000);
    chk("t2_grants", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("t2_order", grant_log[k], k % N);
    chk("t2_frames", frames, 8);

    // 3: req2 arrives while req0 owns the line
    grant_log.delete();
    for (int k = 0; k < 3; k++) pend_q[0].push_back(8'(8'h30 + k));
    c = 0;
    while (grant_log.size() == 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("t3_first_grant", 32'(c < 500), 1);
    pend_q[2].push_back(8'h5C);
    quiet("t3", 3000);
    chk("t3_grants", grant_log.size(), 4);
    if (grant_log.size() >= 3) begin
      chk("t3_o0", grant_log[0], 0);
      chk("t3_o1", grant_log[1], 2);
      chk("t3_o2", grant_log[2], 0);
    end
    chk("t3_frames", frames, 12);

    // 4: transmitter never goes busy
    stub_never = 1'b1;
    pend_q[1].push_back(8'h44);
    quiet("t4a", 500);
    chk("t4_err", terr, 1);
    chk("t4_frames", frames, 12);
    stub_never = 1'b0;
    stub_d     = 2;
    pend_q[3].push_back(8'h33);
    quiet("t4b", 500);
    chk("t4_err_sticky", terr, 1);
    chk("t4_frames2", frames, 13);

    // 5: reset while waiting for busy to fall
    stub_len = 200;
    pend_q[3].push_back(8'h77);
    c = 0;
    while (!(active && !ifc.tx_start && ifc.tx_busy) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("t5_in_wait", 32'(c < 500), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend_q[i].delete();
    #1;
    chk_zero("t5_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stub_len = 10;
    for (int i = 0; i < N; i++) pend_q[i].push_back(8'(8'h50 + i));
    quiet("t5", 2000);
    chk("t5_grants", grant_log.size(), 4);
    if (grant_log.size() > 0) chk("t5_first", grant_log[0], 0);
    chk("t5_frames", frames, 4);

    // 6: busy seen on the timeout cycle, then one cycle too late
    stub_d = 63;
    pend_q[1].push_back(8'h66);
    quiet("t6a", 500);
    chk("t6_err", terr, 0);
    chk("t6_frames", frames, 5);
    stub_d = 64;
    pend_q[2].push_back(8'h67);
    quiet("t6b", 500);
    chk("t6_err_late", terr, 1);
    chk("t6_frames_late", frames, 5);

    // random batches under random stub behaviour
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      stub_never = (r == 0);
      stub_d     = (r == 1) ? 63 : (r == 2) ? 64 : $urandom_range(2, 8);
      stub_len   = $urandom_range(5, 12);
      mask       = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++)
        if (mask[i])
          repeat ($urandom_range(1, 2))
            pend_q[i].push_back(8'($urandom));
      quiet("rand", 3000);
    end
    chk("rand_frames", frames, exp_frames);
    chk("rand_err", terr, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
